// File: rtl/branch_pc_unit_pkg.sv
// Shared constants and state type for the branch / program-counter unit.
package branch_pc_unit_pkg;

  localparam logic [2:0] COND_NONE = 3'b000;
  localparam logic [2:0] COND_BLTZ = 3'b001;
  localparam logic [2:0] COND_BZ   = 3'b010;
  localparam logic [2:0] COND_BNZ  = 3'b011;
  localparam logic [2:0] COND_BCY  = 3'b100;
  localparam logic [2:0] COND_BNCY = 3'b101;

  localparam logic [1:0] ADDR_LONG  = 2'b00;
  localparam logic [1:0] ADDR_REG   = 2'b01;
  localparam logic [1:0] ADDR_SHORT = 2'b10;
  localparam logic [1:0] ADDR_RSVD  = 2'b11;

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } state_t;

endpackage

// File: rtl/branch_pc_unit_if.sv
// Control-unit side of the branch unit: decoded branch controls in, fetch address and status out.
interface branch_pc_unit_if #(
  parameter int PC_W    = 32,
  parameter int IMM_L_W = 26,
  parameter int IMM_S_W = 16
);
  logic               stall;
  logic [2:0]         cond_jump;
  logic               uncond_jump;
  logic [1:0]         addr_sel;
  logic               halt;
  logic [PC_W-1:0]    rs_val;
  logic [IMM_L_W-1:0] imm_long;
  logic [IMM_S_W-1:0] imm_short;
  logic               alu_carry;
  logic               flag_we;

  logic [PC_W-1:0]    pc;
  logic [PC_W-1:0]    pc_plus4;
  logic [PC_W-1:0]    link;
  logic               taken;
  logic               carry_flag;
  logic               halted;

  modport master (
    output stall, cond_jump, uncond_jump, addr_sel, halt, rs_val,
           imm_long, imm_short, alu_carry, flag_we,
    input  pc, pc_plus4, link, taken, carry_flag, halted
  );

  modport slave (
    input  stall, cond_jump, uncond_jump, addr_sel, halt, rs_val,
           imm_long, imm_short, alu_carry, flag_we,
    output pc, pc_plus4, link, taken, carry_flag, halted
  );

endinterface

// File: rtl/branch_cond_eval.sv
// Branch condition evaluator: decodes the CondJump code against rs_val and the stored carry.
// Latency: purely combinational. Backpressure: none, no state.
module branch_cond_eval
  import branch_pc_unit_pkg::*;
#(
  parameter int PC_W = 32
) (
  input  logic [2:0]      cond_jump,
  input  logic [PC_W-1:0] rs_val,
  input  logic            carry_flag,
  output logic            cond_true
);

  always_comb begin
    cond_true = 1'b0;
    case (cond_jump)
      COND_BLTZ: cond_true = rs_val[PC_W-1];
      COND_BZ:   cond_true = (rs_val == '0);
      COND_BNZ:  cond_true = (rs_val != '0);
      COND_BCY:  cond_true = carry_flag;
      COND_BNCY: cond_true = ~carry_flag;
      // none and the two reserved codes never branch
      default:   cond_true = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_pc_unit.sv
// Program counter, carry flag and run/halt FSM; resolves branches and drives the fetch address.
// Latency: decision combinational, new PC visible one edge later. Backpressure: stall freezes all state.
module branch_pc_unit
  import branch_pc_unit_pkg::*;
#(
  parameter int              PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int              IMM_L_W  = 26,
  parameter int              IMM_S_W  = 16
) (
  input logic               clk,
  input logic               rst_n,
  branch_pc_unit_if.slave   bus
);

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            carry_q, carry_d;

  logic            cond_true;
  logic            taken;
  logic [PC_W-1:0] pc_plus4;
  logic [PC_W-1:0] off_long;
  logic [PC_W-1:0] off_short;
  logic [PC_W-1:0] target;

  branch_cond_eval #(
    .PC_W (PC_W)
  ) u_cond_eval (
    .cond_jump  (bus.cond_jump),
    .rs_val     (bus.rs_val),
    .carry_flag (carry_q),
    .cond_true  (cond_true)
  );

  // Word offsets: sign-extend to PC width, then scale to bytes; overflow wraps silently.
  always_comb begin
    pc_plus4  = pc_q + PC_W'(4);
    off_long  = {{(PC_W-IMM_L_W){bus.imm_long[IMM_L_W-1]}}, bus.imm_long} << 2;
    off_short = {{(PC_W-IMM_S_W){bus.imm_short[IMM_S_W-1]}}, bus.imm_short} << 2;
    target    = pc_plus4;
    case (bus.addr_sel)
      ADDR_LONG:  target = pc_plus4 + off_long;
      ADDR_REG:   target = bus.rs_val;
      ADDR_SHORT: target = pc_plus4 + off_short;
      default:    target = pc_plus4;
    endcase
  end

  always_comb begin
    taken = (bus.uncond_jump | cond_true)
          & (state_q == RUN)
          & ~bus.halt
          & (bus.addr_sel != ADDR_RSVD);
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    carry_d = carry_q;
    if (state_q == RUN && !bus.stall) begin
      if (bus.flag_we) begin
        carry_d = bus.alu_carry;
      end
      // halt parks the PC on the halt instruction itself
      if (bus.halt) begin
        state_d = HALTED;
      end else if (taken) begin
        pc_d = target;
      end else begin
        pc_d = pc_plus4;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      carry_q <= carry_d;
    end
  end

  assign bus.pc         = pc_q;
  assign bus.pc_plus4   = pc_plus4;
  assign bus.link       = pc_plus4;
  assign bus.taken      = taken;
  assign bus.carry_flag = carry_q;
  assign bus.halted     = (state_q == HALTED);

endmodule

// File: tb/tb_branch_pc_unit.sv
// Scoreboarded bench: driver pushes expected outputs from a behavioural model, monitor compares.
module tb_branch_pc_unit;

  localparam int PC_W = 32;
  localparam int IMM_L_W = 26;
  localparam int IMM_S_W = 16;

  typedef struct {
    bit                 rst_n;
    bit                 stall;
    bit [2:0]           cond;
    bit                 uncond;
    bit [1:0]           asel;
    bit                 halt;
    bit [PC_W-1:0]      rs;
    bit [IMM_L_W-1:0]   il;
    bit [IMM_S_W-1:0]   is;
    bit                 ac;
    bit                 fwe;
  } stim_t;

  typedef struct {
    bit [PC_W-1:0] pc;
    bit [PC_W-1:0] pc_plus4;
    bit            taken;
    bit            carry;
    bit            halted;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  branch_pc_unit_if #(.PC_W(PC_W), .IMM_L_W(IMM_L_W), .IMM_S_W(IMM_S_W)) bus ();

  branch_pc_unit #(
    .PC_W(PC_W), .RESET_PC('0), .IMM_L_W(IMM_L_W), .IMM_S_W(IMM_S_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  exp_t q[$];
  int tests = 0;
  int fails = 0;

  bit [PC_W-1:0] m_pc;
  bit            m_carry;
  bit            m_halted;

  task automatic chk(input string name, input logic [PC_W-1:0] act, input logic [PC_W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (pc model %h)", name, act, exp, m_pc);
    end
  endtask

  // Monitor: the unit presents its outputs every cycle; compare whenever an expectation is pending.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("pc",         bus.pc,                e.pc);
        chk("pc_plus4",   bus.pc_plus4,          e.pc_plus4);
        chk("link",       bus.link,              e.pc_plus4);
        chk("taken",      PC_W'(bus.taken),      PC_W'(e.taken));
        chk("carry_flag", PC_W'(bus.carry_flag), PC_W'(e.carry));
        chk("halted",     PC_W'(bus.halted),     PC_W'(e.halted));
      end
    end
  end

  function automatic bit model_cond(input stim_t s);
    if (s.cond == 3'd1) return s.rs[PC_W-1];
    if (s.cond == 3'd2) return s.rs == 0;
    if (s.cond == 3'd3) return s.rs != 0;
    if (s.cond == 3'd4) return m_carry;
    if (s.cond == 3'd5) return !m_carry;
    return 1'b0;
  endfunction

  task automatic step(input stim_t s);
    exp_t e;
    int off;
    bit [PC_W-1:0] tgt;
    bit tk;
    @(posedge clk);
    #1;
    rst_n           = s.rst_n;
    bus.stall       = s.stall;
    bus.cond_jump   = s.cond;
    bus.uncond_jump = s.uncond;
    bus.addr_sel    = s.asel;
    bus.halt        = s.halt;
    bus.rs_val      = s.rs;
    bus.imm_long    = s.il;
    bus.imm_short   = s.is;
    bus.alu_carry   = s.ac;
    bus.flag_we     = s.fwe;

    tk = (s.uncond || model_cond(s)) && !m_halted && !s.halt && s.asel != 2'b11;
    if (s.asel == 2'b00) begin
      off = $signed(s.il);
      tgt = m_pc + 4 + PC_W'(off * 4);
    end else if (s.asel == 2'b10) begin
      off = $signed(s.is);
      tgt = m_pc + 4 + PC_W'(off * 4);
    end else begin
      tgt = s.rs;
    end

    e.pc = m_pc; e.pc_plus4 = m_pc + 4; e.taken = tk;
    e.carry = m_carry; e.halted = m_halted;
    q.push_back(e);

    if (!s.rst_n) begin
      m_pc = '0; m_carry = 1'b0; m_halted = 1'b0;
    end else if (!m_halted && !s.stall) begin
      if (s.fwe) m_carry = s.ac;
      if (s.halt) m_halted = 1'b1;
      else if (tk) m_pc = tgt;
      else m_pc = m_pc + 4;
    end
  endtask

  function automatic stim_t nop();
    stim_t s;
    s.rst_n = 1; s.stall = 0; s.cond = 0; s.uncond = 0; s.asel = 0; s.halt = 0;
    s.rs = 0; s.il = 0; s.is = 0; s.ac = 0; s.fwe = 0;
    return s;
  endfunction

  task automatic br_to(input bit [PC_W-1:0] a, input bit fwe, input bit ac);
    stim_t s = nop();
    s.uncond = 1; s.asel = 2'b01; s.rs = a; s.fwe = fwe; s.ac = ac;
    step(s);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time exhausted, got running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    stim_t s;
    s = nop(); s.rst_n = 0;
    rst_n = 0;
    bus.stall = 0; bus.cond_jump = 0; bus.uncond_jump = 0; bus.addr_sel = 0;
    bus.halt = 0; bus.rs_val = 0; bus.imm_long = 0; bus.imm_short = 0;
    bus.alu_carry = 0; bus.flag_we = 0;
    repeat (2) @(posedge clk);
    m_pc = '0; m_carry = 0; m_halted = 0;

    // free run from reset
    repeat (4) step(nop());

    // bz with short offset, taken and not taken
    br_to(32'h100, 0, 0);
    s = nop(); s.asel = 2'b10; s.cond = 3'b010; s.rs = 0; s.is = 16'hFFFE; step(s);
    br_to(32'h100, 0, 0);
    s.rs = 5; step(s);

    // carry flag set, then bncy / bcy
    br_to(32'h20, 1, 1);
    s = nop(); s.cond = 3'b101; s.il = 26'd8; step(s);
    s.cond = 3'b100; step(s);

    // br and bl
    br_to(32'h400, 0, 0);
    br_to(32'h10, 0, 0);
    s = nop(); s.uncond = 1; s.il = 26'd3; step(s);

    // halt holds until reset
    br_to(32'h30, 0, 0);
    s = nop(); s.halt = 1; step(s);
    s = nop(); s.uncond = 1; s.asel = 2'b01; s.rs = 32'h77; s.fwe = 1; s.ac = 1;
    repeat (3) step(s);
    s = nop(); s.rst_n = 0; step(s);
    step(nop());

    // stall masks halt
    s = nop(); s.stall = 1; s.halt = 1; repeat (2) step(s);
    s.stall = 0; step(s);
    step(nop());
    s = nop(); s.rst_n = 0; step(s);

    // wrap-around
    br_to(32'hFFFF_FFFC, 0, 0);
    repeat (2) step(nop());

    // reserved addr_sel never redirects
    s = nop(); s.uncond = 1; s.asel = 2'b11; s.rs = 32'h500; step(s);
    step(nop());

    // randomized traffic
    for (int i = 0; i < 2000; i++) begin
      s.rst_n  = ($urandom_range(0, 40) != 0);
      s.stall  = ($urandom_range(0, 7) == 0);
      s.halt   = ($urandom_range(0, 63) == 0);
      s.cond   = 3'($urandom_range(0, 7));
      s.uncond = ($urandom_range(0, 3) == 0);
      s.asel   = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 3))
        0: s.rs = '0;
        1: s.rs = 32'h8000_0000 | $urandom;
        default: s.rs = $urandom;
      endcase
      s.il  = IMM_L_W'($urandom);
      s.is  = IMM_S_W'($urandom);
      s.ac  = 1'($urandom);
      s.fwe = 1'($urandom);
      step(s);
    end

    repeat (2) @(negedge clk);
    #1;
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
